// File: rtl/bp_me_fwd_rev_steer.sv
// Address-window steering stage: mem_fwd streams go to the device or loopback port,
// and mem_rev streams from both ports are merged upstream with per-message locking and round-robin.
module bp_me_fwd_rev_steer #(
  parameter int                       paddr_width_p          = 40,
  parameter int                       bedrock_fill_width_p   = 64,
  parameter int                       cce_block_width_p      = 512,
  parameter int                       mem_fwd_header_width_p = 64,
  parameter int                       mem_rev_header_width_p = 64,
  parameter logic [15:0]              fwd_stream_mask_p      = 16'h002A,
  parameter logic [15:0]              rev_stream_mask_p      = 16'h0025,
  parameter logic [paddr_width_p-1:0] dev_base_addr_p        = '0,
  parameter logic [paddr_width_p-1:0] dev_mask_p             = '0
) (
  input  logic                              clk_i,
  input  logic                              reset_i,

  input  logic [mem_fwd_header_width_p-1:0] mem_fwd_header_i,
  input  logic [bedrock_fill_width_p-1:0]   mem_fwd_data_i,
  input  logic                              mem_fwd_v_i,
  output logic                              mem_fwd_ready_and_o,

  output logic [mem_rev_header_width_p-1:0] mem_rev_header_o,
  output logic [bedrock_fill_width_p-1:0]   mem_rev_data_o,
  output logic                              mem_rev_v_o,
  input  logic                              mem_rev_ready_and_i,

  output logic [mem_fwd_header_width_p-1:0] dev_fwd_header_o,
  output logic [bedrock_fill_width_p-1:0]   dev_fwd_data_o,
  output logic                              dev_fwd_v_o,
  input  logic                              dev_fwd_ready_and_i,

  input  logic [mem_rev_header_width_p-1:0] dev_rev_header_i,
  input  logic [bedrock_fill_width_p-1:0]   dev_rev_data_i,
  input  logic                              dev_rev_v_i,
  output logic                              dev_rev_ready_and_o,

  output logic [mem_fwd_header_width_p-1:0] lb_fwd_header_o,
  output logic [bedrock_fill_width_p-1:0]   lb_fwd_data_o,
  output logic                              lb_fwd_v_o,
  input  logic                              lb_fwd_ready_and_i,

  input  logic [mem_rev_header_width_p-1:0] lb_rev_header_i,
  input  logic [bedrock_fill_width_p-1:0]   lb_rev_data_i,
  input  logic                              lb_rev_v_i,
  output logic                              lb_rev_ready_and_o
);

  localparam int max_beats_lp = cce_block_width_p / bedrock_fill_width_p;
  localparam int cnt_w_lp     = $clog2(max_beats_lp) + 1;
  // Header layout: [3:0] msg_type, [7:4] subop, addr at [8 +: paddr], size right above addr.
  localparam int addr_off_lp  = 8;
  localparam int size_off_lp  = addr_off_lp + paddr_width_p;

  typedef enum logic {e_idle, e_locked} state_e;

  function automatic logic [cnt_w_lp-1:0] f_beats(input logic [3:0]  msg_type,
                                                 input logic [2:0]  size,
                                                 input logic [15:0] stream_mask);
    logic [31:0] w_bits;
    logic [31:0] w_n;
    // NOTE: every local gets a value on every path, so no storage is implied when used in logic.
    w_bits = 32'd8 << size;
    w_n    = w_bits / 32'(bedrock_fill_width_p);
    if (!stream_mask[msg_type] || (w_n == 32'd0)) w_n = 32'd1;
    else if (w_n > 32'(max_beats_lp))             w_n = 32'(max_beats_lp);
    return cnt_w_lp'(w_n);
  endfunction

  // ---------------- forward path ----------------
  state_e                r_fwd_state;
  logic                  r_fwd_to_dev;
  logic [cnt_w_lp-1:0]   r_fwd_cnt;
  logic                  w_fwd_hit;
  logic                  w_fwd_to_dev;
  logic                  w_fwd_hs;
  logic [cnt_w_lp-1:0]   w_fwd_beats;

  assign w_fwd_hit    = (mem_fwd_header_i[addr_off_lp +: paddr_width_p] & dev_mask_p) == dev_base_addr_p;
  assign w_fwd_to_dev = (r_fwd_state == e_locked) ? r_fwd_to_dev : w_fwd_hit;
  assign w_fwd_beats  = f_beats(mem_fwd_header_i[3:0], mem_fwd_header_i[size_off_lp +: 3], fwd_stream_mask_p);

  assign dev_fwd_header_o    = mem_fwd_header_i;
  assign dev_fwd_data_o      = mem_fwd_data_i;
  assign lb_fwd_header_o     = mem_fwd_header_i;
  assign lb_fwd_data_o       = mem_fwd_data_i;
  assign dev_fwd_v_o         = ~reset_i & mem_fwd_v_i &  w_fwd_to_dev;
  assign lb_fwd_v_o          = ~reset_i & mem_fwd_v_i & ~w_fwd_to_dev;
  assign mem_fwd_ready_and_o = ~reset_i & (w_fwd_to_dev ? dev_fwd_ready_and_i : lb_fwd_ready_and_i);
  assign w_fwd_hs            = mem_fwd_v_i & mem_fwd_ready_and_o;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_fwd_state  <= e_idle;
      r_fwd_to_dev <= 1'b0;
      r_fwd_cnt    <= '0;
    end else if (w_fwd_hs) begin
      if (r_fwd_state == e_idle) begin
        if (w_fwd_beats > cnt_w_lp'(1)) begin
          r_fwd_state  <= e_locked;
          r_fwd_cnt    <= w_fwd_beats - cnt_w_lp'(1);
          r_fwd_to_dev <= w_fwd_hit;
        end
      end else begin
        r_fwd_cnt <= r_fwd_cnt - cnt_w_lp'(1);
        if (r_fwd_cnt == cnt_w_lp'(1)) r_fwd_state <= e_idle;
      end
    end
  end

  // ---------------- reverse path ----------------
  state_e                r_rev_state;
  logic                  r_rev_grant_lb;
  logic                  r_rr;
  logic [cnt_w_lp-1:0]   r_rev_cnt;
  logic                  w_rev_grant_lb;
  logic                  w_rev_hs;
  logic [cnt_w_lp-1:0]   w_rev_beats;

  // r_rr = 0 prefers the device when both sources are valid.
  assign w_rev_grant_lb = (r_rev_state == e_locked) ? r_rev_grant_lb
                        : ((dev_rev_v_i & lb_rev_v_i) ? r_rr : lb_rev_v_i);

  assign mem_rev_header_o    = w_rev_grant_lb ? lb_rev_header_i : dev_rev_header_i;
  assign mem_rev_data_o      = w_rev_grant_lb ? lb_rev_data_i   : dev_rev_data_i;
  assign mem_rev_v_o         = ~reset_i & (w_rev_grant_lb ? lb_rev_v_i : dev_rev_v_i);
  assign dev_rev_ready_and_o = ~reset_i & ~w_rev_grant_lb & mem_rev_ready_and_i;
  assign lb_rev_ready_and_o  = ~reset_i &  w_rev_grant_lb & mem_rev_ready_and_i;
  assign w_rev_hs            = mem_rev_v_o & mem_rev_ready_and_i;
  assign w_rev_beats         = f_beats(mem_rev_header_o[3:0], mem_rev_header_o[size_off_lp +: 3], rev_stream_mask_p);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_rev_state    <= e_idle;
      r_rev_grant_lb <= 1'b0;
      r_rr           <= 1'b0;
      r_rev_cnt      <= '0;
    end else if (w_rev_hs) begin
      if (r_rev_state == e_idle) begin
        if (w_rev_beats > cnt_w_lp'(1)) begin
          r_rev_state    <= e_locked;
          r_rev_cnt      <= w_rev_beats - cnt_w_lp'(1);
          r_rev_grant_lb <= w_rev_grant_lb;
        end else begin
          r_rr <= ~w_rev_grant_lb;
        end
      end else begin
        r_rev_cnt <= r_rev_cnt - cnt_w_lp'(1);
        if (r_rev_cnt == cnt_w_lp'(1)) begin
          r_rev_state <= e_idle;
          r_rr        <= ~r_rev_grant_lb;
        end
      end
    end
  end

endmodule
